// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation datapath stages
// (long-division reducer and Montgomery multiplier).
package rsa_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A requested length of 0, or one wider than the operand, means "whole operand".
  function automatic int unsigned eff_len(input logic [31:0] len, input int unsigned w);
    if ((len == 32'd0) || (len > w)) begin
      return w;
    end
    return len;
  endfunction

endpackage

// File: rtl/mod_reduce_seq_if.sv
// Start/busy/done request bus between the exponentiation controller and the reducer.
interface mod_reduce_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] N;
  logic [31:0]  len;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] out;

  modport master (
    output start, A, N, len,
    input  busy, done, err, out
  );

  modport slave (
    input  start, A, N, len,
    output busy, done, err, out
  );
endinterface

// File: rtl/cond_sub.sv
// Conditional subtract: r = (t >= n) ? t - n : t. Shared with the Montgomery final
// correction step, so the width is a parameter.
module cond_sub
  import rsa_pkg::*;
#(
  parameter int WIDTH = W_DEFAULT + 1
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] r_o
);

  always_comb begin
    r_o = (t_i >= n_i) ? (t_i - n_i) : t_i;
  end

endmodule

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring reducer: out = A mod N, one operand bit per clock, MSB first.
// Feeds reduced operands into the Montgomery multiplier.
module mod_reduce_seq
  import rsa_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rstn,
  mod_reduce_seq_if.slave bus
);

  state_e             state_q, state_d;
  logic [W-1:0]       r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       n_q, n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [W-1:0]       out_q, out_d;

  logic [W-1:0]       bit_hit;
  logic               a_bit;
  logic [W:0]         t_val;
  logic [W:0]         sub_res;
  logic               sub_msb_unused;

  // Select A_cap[cnt] as an OR of one-hot matches; avoids an oversized index.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit_sel
      assign bit_hit[gi] = (cnt_q == CNT_W'(gi)) & a_q[gi];
    end
  endgenerate

  assign a_bit = |bit_hit;
  assign t_val = {r_q, a_bit};

  // R < N before each step, so T < 2N and a single W+1-bit subtract restores R < N.
  cond_sub #(
    .WIDTH(W + 1)
  ) u_cond_sub (
    .t_i(t_val),
    .n_i({1'b0, n_q}),
    .r_o(sub_res)
  );

  assign sub_msb_unused = sub_res[W];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.A;
          n_d = bus.N;
          if (bus.N == '0) begin
            out_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            r_d     = '0;
            cnt_d   = CNT_W'(eff_len(bus.len, W) - 1);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        r_d = sub_res[W-1:0];
        if (cnt_q == '0) begin
          out_d   = sub_res[W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.out  = out_q;

endmodule

// File: doc/mod_reduce_seq.md
Name: mod_reduce_seq

Overview:
- Sequential bit-serial modular reducer: computes out = A mod N by restoring shift-subtract, one operand bit per clock, MSB first.
- Sits directly upstream of the Montgomery multiplier in the modular-exponentiation datapath. It brings raw operands into the range [0, N) before multiplication.
- Start/busy/done handshake, so the exponentiation controller can sequence it.

Parameters:
- W, 32, operand/modulus width in bits.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  reset; synchronous, active-high (asserted = 1).
- start  input  1  request; sampled only when busy = 0.
- A  input  W  operand to reduce.
- N  input  W  modulus.
- len  input  32  number of low-order bits of A to process; 0 or > W means W.
- busy  output  1  high from the edge after start is accepted until the result edge.
- done  output  1  one-cycle pulse when out/err are updated.
- err  output  1  1 when the last operation had N = 0; valid with done, held until next done.
- out  output  W  result; held until next done.

Behaviour:
- Reset, when rstn = 1 at an edge:
  - state = IDLE; busy, done, err = 0; out = 0; internal R and counter = 0.
  - Applies mid-operation; any in-flight operation is discarded with no done.
- States: IDLE, RUN. The done pulse is a registered flag, not a separate state.
- IDLE, start = 1 at edge e0:
  - Capture A, N and L = effective len.
  - If N = 0: next edge stays IDLE; out <= 0, err <= 1, done <= 1 for one cycle, no RUN.
  - Otherwise: R <= 0, cnt <= L-1, busy <= 1, state <= RUN.
- RUN, each edge:
  - T = {R, A_cap[cnt]}, W+1 bits.
  - R <= (T >= N) ? T - N : T.
  - If cnt = 0: out <= that value, err <= 0, done <= 1, busy <= 0, state <= IDLE. Otherwise cnt <= cnt-1.
- Latency: with start accepted at e0, done is high in the cycle after edge e_L (L edges after acceptance). out is valid from that cycle.
- Width rule: invariant R < N holds before each step.
  - So T ≤ 2N-1 < 2^(W+1), and one conditional subtract suffices.
  - The compare/subtract is done at W+1 bits.
- Input changes on A/N/len during RUN have no effect (captured copies only).
- start while busy = 1 is ignored, neither queued nor flagged.
- start in the cycle done = 1 (state IDLE) is accepted; back-to-back operations have no bubble beyond the done cycle.
- done clears on the following edge unless a new result is produced that edge. A result cannot be produced that edge when L ≥ 1.
- A < N with L = W gives out = A. Bits of A above L-1 are ignored.

Decomposition:
- Shared package rsa_pkg:
  - W default; state encoding (IDLE = 0, RUN = 1).
  - Function eff_len(len) implementing the 0/>W clamp.
  - Shared by the long-division and Montgomery stages.
- One natural combinational sub-module, cond_sub: (T, N) -> (T ≥ N ? T-N : T), width W+1. It is reusable by the final subtraction of the Montgomery multiplier.
- Everything else stays inline.

Test Plan:
- Basic reduction: A = 100, N = 7, len = 32, pulse start:
  - busy high for 32 cycles, done pulse 32 edges after acceptance.
  - out = 2, err = 0.
- Truncated length: A = 0xFFFFFF0D, N = 10, len = 8:
  - only 0x0D processed; out = 3, done 8 edges after acceptance.
  - len = 0 with A = 100, N = 7 behaves as len = 32 (out = 2).
- Extreme values:
  - A = 0xFFFFFFFF, N = 0xFFFFFFFE -> out = 1.
  - A = 0xFFFFFFFF, N = 0x80000000 -> out = 0x7FFFFFFF.
  - A = 5, N = 0xFFFFFFFF -> out = 5.
  - Checks the W+1-bit compare.
- Zero modulus: N = 0, A = 123 -> done one edge after acceptance, busy never high, err = 1, out = 0. A subsequent valid op clears err.
- Handshake:
  - start held high during RUN, and A changed mid-run, -> result of the originally captured A only, single done.
  - start asserted in the done cycle -> second op accepted, correct second result after L more edges.
- Reset mid-operation: rstn = 1 at cycle 10 of a 32-bit op:
  - busy, done, err, out all 0 next cycle, no done pulse.
  - A new start after reset completes normally.
